// File: rtl/fetch_pc_predict_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_predict_if
// Bundle of the fetch-stage PC generator signals.
//   master : hazard/execute side. Drives stall, redirect and training inputs
//            and observes the fetch outputs.
//   slave  : the PC generator itself.
// Signals:
//   StallF, RedirectE, RedirectPCE        - next-PC control
//   UpdateE, UpdatePCE, UpdateTakenE,
//   UpdateTargetE                          - predictor training from execute
//   pcF, PCPlus4F, branch_predictF,
//   PredTargetF                            - fetch outputs
// -----------------------------------------------------------------------------
interface fetch_pc_predict_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  StallF;
    logic                  RedirectE;
    logic [DATA_WIDTH-1:0] RedirectPCE;
    logic                  UpdateE;
    logic [DATA_WIDTH-1:0] UpdatePCE;
    logic                  UpdateTakenE;
    logic [DATA_WIDTH-1:0] UpdateTargetE;
    logic [DATA_WIDTH-1:0] pcF;
    logic [DATA_WIDTH-1:0] PCPlus4F;
    logic                  branch_predictF;
    logic [DATA_WIDTH-1:0] PredTargetF;

    modport master (
        output StallF, RedirectE, RedirectPCE,
        output UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
        input  pcF, PCPlus4F, branch_predictF, PredTargetF
    );

    modport slave (
        input  StallF, RedirectE, RedirectPCE,
        input  UpdateE, UpdatePCE, UpdateTakenE, UpdateTargetE,
        output pcF, PCPlus4F, branch_predictF, PredTargetF
    );
endinterface

// File: rtl/fetch_pc_predict.sv
// -----------------------------------------------------------------------------
// fetch_pc_predict
// Fetch-stage PC register with a direct-mapped branch predictor (2-bit
// saturating counter BHT plus tagged BTB). pcF is also the i_mem address.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - fetch_pc_predict_if.slave (stall/redirect in, training in,
//            pcF/PCPlus4F/branch_predictF/PredTargetF out)
//
// Configuration macro: BRANCH_PREDICT_EN
//   defined   - predictor tables and training present
//   undefined - static not-taken; Update* inputs ignored, prediction tied 0
//
// Next-PC priority: redirect > stall > predicted target > pcF + 4.
// -----------------------------------------------------------------------------
module fetch_pc_predict #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IDX_BITS   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_pc_predict_if.slave   bus
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_pred_taken;
    logic [DATA_WIDTH-1:0] w_pred_target;

    // Wraps modulo 2^DATA_WIDTH by construction.
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

`ifdef BRANCH_PREDICT_EN
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = DATA_WIDTH - IDX_BITS - 2;

    logic [1:0]            r_ctr    [ENTRIES];
    logic                  r_valid  [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [ENTRIES];

    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [IDX_BITS-1:0]   w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_unused_upd_lsb;

    // 2-bit saturating counter step.
    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign w_idx     = r_pc[IDX_BITS+1:2];
    assign w_tag     = r_pc[DATA_WIDTH-1:IDX_BITS+2];
    assign w_upd_idx = bus.UpdatePCE[IDX_BITS+1:2];
    assign w_upd_tag = bus.UpdatePCE[DATA_WIDTH-1:IDX_BITS+2];

    // Byte offset of the trained PC plays no part in indexing or tagging.
    assign w_unused_upd_lsb = ^bus.UpdatePCE[1:0];

    // Lookup reads registered table state, so a same-cycle training write is
    // seen only from the next cycle on.
    assign w_pred_taken  = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && r_ctr[w_idx][1];
    assign w_pred_target = r_target[w_idx];

    // Training ignores stall and redirect; only reset discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i]    <= 2'b01;
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (bus.UpdateE) begin
            r_ctr[w_upd_idx] <= f_ctr_next(r_ctr[w_upd_idx], bus.UpdateTakenE);
            // Not-taken outcomes leave the BTB entry alone.
            if (bus.UpdateTakenE) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= bus.UpdateTargetE;
            end
        end
    end
`else
    logic w_unused_update;

    assign w_pred_taken    = 1'b0;
    assign w_pred_target   = '0;
    assign w_unused_update = ^{bus.UpdateE, bus.UpdatePCE, bus.UpdateTakenE, bus.UpdateTargetE};
`endif

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (bus.RedirectE)
            w_pc_next = bus.RedirectPCE;
        else if (bus.StallF)
            w_pc_next = r_pc;
        else if (w_pred_taken)
            w_pc_next = w_pred_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    assign bus.pcF             = r_pc;
    assign bus.PCPlus4F        = w_pc_plus4;
    assign bus.branch_predictF = w_pred_taken;
    assign bus.PredTargetF     = w_pred_target;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_predict
// Directed bench for fetch_pc_predict. Expected values are hand-computed;
// predictor-dependent expectations follow BRANCH_PREDICT_EN.
// -----------------------------------------------------------------------------
module tb_fetch_pc_predict;

`ifdef BRANCH_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_pc_predict_if #(.DATA_WIDTH(32)) bus ();

    fetch_pc_predict #(
        .DATA_WIDTH (32),
        .IDX_BITS   (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.RedirectE   = 1'b1;
        bus.RedirectPCE = target;
        tick();
        bus.RedirectE   = 1'b0;
    endtask

    initial begin
        bus.StallF        = 1'b0;
        bus.RedirectE     = 1'b0;
        bus.RedirectPCE   = '0;
        bus.UpdateE       = 1'b0;
        bus.UpdatePCE     = '0;
        bus.UpdateTakenE  = 1'b0;
        bus.UpdateTargetE = '0;

        // Reset state
        tick();
        tick();
        chk("rst_pcF",      bus.pcF,             32'h0);
        chk("rst_PCPlus4F", bus.PCPlus4F,        32'h4);
        chk("rst_bp",       bus.branch_predictF, 32'h0);
        chk("rst_target",   bus.PredTargetF,     32'h0);

        // Sequential fetch
        rst_n = 1'b1;
        tick(); chk("seq_pc4",  bus.pcF, 32'h4);
        tick(); chk("seq_pc8",  bus.pcF, 32'h8);
        tick(); chk("seq_pc12", bus.pcF, 32'hC);
        chk("seq_bp", bus.branch_predictF, 32'h0);
        repeat (5) tick();
        chk("seq_pc20", bus.pcF, 32'h20);

        // Stall holds, redirect overrides stall
        bus.StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.pcF, 32'h20);
        end
        redirect(32'h100);
        chk("redir_over_stall", bus.pcF, 32'h100);
        bus.StallF = 1'b0;

        // Single taken training pulse: ctr 01 -> 10, already predicts taken
        bus.UpdateE       = 1'b1;
        bus.UpdatePCE     = 32'h10;
        bus.UpdateTakenE  = 1'b1;
        bus.UpdateTargetE = 32'h40;
        tick();
        bus.UpdateE = 1'b0;
        chk("train_seq_pc", bus.pcF, 32'h104);
        redirect(32'h10);
        chk("pred_pc",     bus.pcF,             32'h10);
        chk("pred_bp",     bus.branch_predictF, {31'b0, PRED});
        chk("pred_target", bus.PredTargetF,     PRED ? 32'h40 : 32'h0);
        tick();
        chk("pred_next_pc", bus.pcF, PRED ? 32'h40 : 32'h14);

        // Tag alias: same index, different tag
        redirect(32'h50);
        chk("alias_pc", bus.pcF,             32'h50);
        chk("alias_bp", bus.branch_predictF, 32'h0);
        tick();
        chk("alias_next_pc", bus.pcF, 32'h54);

        // Saturation and decay, trained while stalled
        bus.StallF       = 1'b1;
        bus.UpdateE      = 1'b1;
        bus.UpdatePCE    = 32'h10;
        bus.UpdateTakenE = 1'b1;
        repeat (4) tick();
        chk("sat_stall_pc", bus.pcF, 32'h54);
        bus.UpdateTakenE = 1'b0;
        redirect(32'h10);
        chk("decay1_pc", bus.pcF,             32'h10);
        chk("decay1_bp", bus.branch_predictF, {31'b0, PRED});
        tick();
        bus.UpdateE = 1'b0;
        chk("decay2_pc", bus.pcF,             32'h10);
        chk("decay2_bp", bus.branch_predictF, 32'h0);
        bus.StallF = 1'b0;
        tick();
        chk("decay2_next_pc", bus.pcF, 32'h14);

        // Wrap and misaligned redirect
        redirect(32'hFFFF_FFFC);
        chk("wrap_pc",     bus.pcF,             32'hFFFF_FFFC);
        chk("wrap_plus4",  bus.PCPlus4F,        32'h0);
        chk("wrap_bp",     bus.branch_predictF, 32'h0);
        tick();
        chk("wrap_next_pc", bus.pcF, 32'h0);
        redirect(32'h103);
        chk("misalign_pc",    bus.pcF,      32'h103);
        chk("misalign_plus4", bus.PCPlus4F, 32'h107);

        // Asynchronous reset mid-operation discards redirect and training
        bus.RedirectE     = 1'b1;
        bus.RedirectPCE   = 32'h200;
        bus.UpdateE       = 1'b1;
        bus.UpdatePCE     = 32'h10;
        bus.UpdateTakenE  = 1'b1;
        bus.UpdateTargetE = 32'h80;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pcF, 32'h0);
        tick();
        bus.RedirectE = 1'b0;
        bus.UpdateE   = 1'b0;
        rst_n         = 1'b1;
        chk("rst_hold_pc", bus.pcF, 32'h0);
        redirect(32'h10);
        chk("post_rst_pc",     bus.pcF,             32'h10);
        chk("post_rst_bp",     bus.branch_predictF, 32'h0);
        chk("post_rst_target", bus.PredTargetF,     32'h0);
        tick();
        chk("post_rst_next_pc", bus.pcF, 32'h14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
